// File: rtl/sample_fifo_pkg.sv
// Shared types and default sizing for the DDC -> FX2 sample buffer.
// Optional build feature: SAMPLE_FIFO_STATS_EN enables overflow statistics.
package sample_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } in_state_e;

  localparam int SAMPLE_DATA_W = 16;
  localparam int SAMPLE_DEPTH  = 512;

endpackage

// File: rtl/sample_fifo_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read (distributed RAM).
module sample_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_fifo.sv
// Sample buffer between the DDC handshake and the FX2 slave-FIFO writer.
// Define SAMPLE_FIFO_STATS_EN to build the overflow counter and sticky flag.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int DATA_W = SAMPLE_DATA_W,
  parameter int DEPTH  = SAMPLE_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_rdy,
  output logic              in_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_rdy,
  input  logic              out_wr_n,
  output logic [AW:0]       level,
  output logic              half_full,
  input  logic              ovf_clr,
  output logic [15:0]       ovf_cnt,
  output logic              ovf_flag
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF = (AW+1)'(DEPTH / 2);

  in_state_e     state;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   level_q;
  logic          take, push, pop;

  assign pop  = !out_wr_n && (level_q != '0);
  assign take = (state == IDLE) && in_rdy;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = take && ((level_q != FULL) || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      in_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_rdy) begin
            state  <= ACK;
            in_ack <= 1'b1;
          end
        end
        ACK: begin
          state  <= WAIT_LOW;
          in_ack <= 1'b0;
        end
        WAIT_LOW: begin
          if (!in_rdy) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          in_ack <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      level_q <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  sample_fifo_ram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wp),
    .wdata (in_data),
    .raddr (rp),
    .rdata (out_data)
  );

  assign out_rdy   = (level_q != '0);
  assign level     = level_q;
  assign half_full = (level_q >= HALF);

`ifdef SAMPLE_FIFO_STATS_EN
  logic drop;
  assign drop = take && !push;

  // A drop coinciding with a clear leaves a count of one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
      if (ovf_clr)                 ovf_cnt <= 16'd1;
      else if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end else if (ovf_clr) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_cnt  = '0;
  assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo with a scoreboard queue of expected words.
module tb_sample_fifo;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic              in_ack;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;
  logic              out_wr_n;
  logic [AW:0]       level;
  logic              half_full;
  logic              ovf_clr;
  logic [15:0]       ovf_cnt;
  logic              ovf_flag;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] sb[$];

`ifdef SAMPLE_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_rdy    (in_rdy),
    .in_ack    (in_ack),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .out_wr_n  (out_wr_n),
    .level     (level),
    .half_full (half_full),
    .ovf_clr   (ovf_clr),
    .ovf_cnt   (ovf_cnt),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One handshake: 3 cycles, inputs driven and outputs sampled on negedges.
  task automatic push(input logic [DATA_W-1:0] d, input bit clr = 1'b0);
    bit acc;
    @(negedge clk);
    chk("ack_idle", in_ack, 1'b0);
    acc = (sb.size() < DEPTH);
    in_rdy  = 1'b1;
    in_data = d;
    ovf_clr = clr;
    @(negedge clk);
    ovf_clr = 1'b0;
    if (acc) sb.push_back(d);
    chk("ack_pulse", in_ack, 1'b1);
    chk("level_push", level, sb.size());
    chk("out_rdy_push", out_rdy, 1'b1);
    chk("half_full", half_full, sb.size() >= DEPTH / 2);
    in_rdy = 1'b0;
    @(negedge clk);
    chk("ack_end", in_ack, 1'b0);
  endtask

  // Back-to-back pops, one per clock, checking show-ahead data before each.
  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("pop_data", out_data, sb[0]);
      chk("pop_rdy", out_rdy, 1'b1);
      out_wr_n = 1'b0;
      @(posedge clk);
      void'(sb.pop_front());
    end
    @(negedge clk);
    out_wr_n = 1'b1;
    chk("level_pop", level, sb.size());
    chk("out_rdy_pop", out_rdy, sb.size() != 0);
  endtask

  initial begin
    int acks;
    rst_n = 1'b0; in_rdy = 1'b0; in_data = '0; out_wr_n = 1'b1; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", in_ack, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_out_rdy", out_rdy, 1'b0);
    chk("rst_half", half_full, 1'b0);
    chk("rst_ovf_cnt", ovf_cnt, 16'd0);
    chk("rst_ovf_flag", ovf_flag, 1'b0);
    rst_n = 1'b1;

    // Single sample
    push(16'h1234);
    chk("first_data", out_data, 16'h1234);
    chk("first_level", level, 1);
    pop_n(1);

    // Fill to full, then drain in order
    for (int i = 0; i < DEPTH; i++) push(DATA_W'(i));
    chk("full_level", level, DEPTH);
    chk("full_half", half_full, 1'b1);
    pop_n(DEPTH);
    chk("drained_rdy", out_rdy, 1'b0);

    // Overflow drop while full
    for (int i = 0; i < DEPTH; i++) push(DATA_W'(16'h100 + i));
    push(16'hAAAA);
    chk("ovf_level", level, DEPTH);
    chk("ovf_cnt", ovf_cnt, STATS ? 16'd1 : 16'd0);
    chk("ovf_flag", ovf_flag, STATS);
    push(16'hAAAB);
    chk("ovf_cnt2", ovf_cnt, STATS ? 16'd2 : 16'd0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clr_cnt", ovf_cnt, 16'd0);
    chk("clr_flag", ovf_flag, 1'b0);
    // Drop in the same cycle as clear
    push(16'hAAAC, 1'b1);
    chk("clr_drop_cnt", ovf_cnt, STATS ? 16'd1 : 16'd0);
    chk("clr_drop_flag", ovf_flag, STATS);

    // Push into a full FIFO with a simultaneous pop
    @(negedge clk);
    chk("fp_data", out_data, sb[0]);
    in_rdy = 1'b1; in_data = 16'hBBBB; out_wr_n = 1'b0;
    @(negedge clk);
    void'(sb.pop_front());
    sb.push_back(16'hBBBB);
    out_wr_n = 1'b1;
    chk("fp_ack", in_ack, 1'b1);
    chk("fp_level", level, DEPTH);
    in_rdy = 1'b0;
    @(negedge clk);
    pop_n(DEPTH - 1);
    chk("fp_last", out_data, 16'hBBBB);
    pop_n(1);

    // Pop while empty has no effect
    @(negedge clk);
    out_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    out_wr_n = 1'b1;
    chk("empty_pop_level", level, 0);
    chk("empty_pop_rdy", out_rdy, 1'b0);
    push(16'h5A5A);
    chk("empty_pop_data", out_data, 16'h5A5A);

    // in_rdy held high long after the ack: single write, single ack
    @(negedge clk);
    in_rdy = 1'b1; in_data = 16'hC0DE;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (in_ack) acks++;
    end
    in_rdy = 1'b0;
    sb.push_back(16'hC0DE);
    repeat (2) @(negedge clk);
    chk("hold_acks", acks, 1);
    chk("hold_level", level, 2);
    pop_n(2);

    // Reset during ACK with 5 words stored; in_rdy kept high through reset
    for (int i = 0; i < 5; i++) push(DATA_W'(16'h200 + i));
    @(negedge clk);
    in_rdy = 1'b1; in_data = 16'hD00D;
    @(negedge clk);
    chk("pre_rst_ack", in_ack, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_rdy", out_rdy, 1'b0);
    chk("mid_rst_ack", in_ack, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back(16'hD00D);
    chk("rst_reack", in_ack, 1'b1);
    chk("rst_dup_level", level, 1);
    chk("rst_dup_data", out_data, 16'hD00D);
    in_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack_end", in_ack, 1'b0);
    pop_n(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
